// File: rtl/uart_rx_lite_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_lite_if
// Description : Serial line in, received-byte strobe and data out for the
//               lightweight 8N1 UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_lite_if;
    logic       i_uart_rx;
    logic       o_wr;
    logic [7:0] o_data;

    // Driver of the serial line and consumer of the received bytes
    modport master (
        output i_uart_rx,
        input  o_wr,
        input  o_data
    );

    // The receiver itself
    modport slave (
        input  i_uart_rx,
        output o_wr,
        output o_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_lite.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_lite
// Description : Lightweight 8N1 UART receiver. Synchronizes the raw serial
//               line, samples each bit at mid-bit using a 24-bit down-counter
//               and presents every correctly framed byte on o_data together
//               with a one-cycle o_wr strobe. No FIFO, no parity.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_lite #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104
) (
    input  wire logic     i_clk,
    input  wire logic     i_rst_n,
    uart_rx_lite_if.slave bus
);

    // Half-bit offset from the start-bit edge to its centre (floor for odd CPB)
    localparam logic [23:0] HALF_BAUD = CLOCKS_PER_BAUD >> 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        rx_meta;
    logic        rx_s;
    logic [23:0] baud_cnt;
    logic [23:0] baud_next;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_next;
    logic [7:0]  shift;
    logic [7:0]  shift_next;
    logic        wr_reg;
    logic        wr_next;
    logic [7:0]  data_reg;
    logic [7:0]  data_next;
    logic        tick;

    // A sample is due when the down-counter has run out
    assign tick = (baud_cnt == 24'd0);

    assign bus.o_wr   = wr_reg;
    assign bus.o_data = data_reg;

    // Two-flop synchronizer for the asynchronous serial line; idles high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            baud_cnt <= 24'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            wr_reg   <= 1'b0;
            data_reg <= 8'h00;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            wr_reg   <= wr_next;
            data_reg <= data_next;
        end
    end

    // Next-state logic: every sample reloads the counter with a full bit
    // period measured from the previous sample, so the sample points are
    // anchored to the start edge and do not drift.
    always_comb begin
        state_next = state;
        baud_next  = tick ? baud_cnt : (baud_cnt - 24'd1);
        bit_next   = bit_cnt;
        shift_next = shift;
        wr_next    = 1'b0;
        data_next  = data_reg;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    baud_next  = HALF_BAUD - 24'd1;
                    bit_next   = 3'd0;
                    state_next = START;
                end
            end

            START: begin
                if (tick) begin
                    if (rx_s) begin
                        // Line back high at the start-bit centre: a glitch
                        state_next = IDLE;
                    end else begin
                        baud_next  = CLOCKS_PER_BAUD - 24'd1;
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    shift_next = {rx_s, shift[7:1]};
                    baud_next  = CLOCKS_PER_BAUD - 24'd1;
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        // Returning to IDLE mid stop bit lets a following
                        // start bit be caught without any idle gap
                        wr_next    = 1'b1;
                        data_next  = shift;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                // A held-low line (break) must not produce repeated frames
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_lite.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_lite
// Description : Self-checking bench for uart_rx_lite. Stimulus drives serial
//               frames and pushes expected (byte, strobe cycle) pairs into a
//               scoreboard; a monitor pops and compares on every o_wr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_lite;

    localparam int CPB  = 104;
    localparam int HALF = CPB / 2;
    // Line edge to strobe: 2 synchronizer cycles, 1 detect cycle, half bit,
    // nine full bits to the stop-bit centre, plus the output register
    localparam int LAT  = 3 + HALF + 9 * CPB;

    typedef struct {
        logic [7:0] data;
        int         when;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;
    logic [7:0] model_data = 8'h00;
    logic       prev_wr    = 1'b0;

    uart_rx_lite_if bus ();

    uart_rx_lite #(
        .CLOCKS_PER_BAUD (24'(CPB))
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Cycle count: after posedge k the count reads k
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: scoreboard compare on strobes, stability of o_data otherwise
    always @(negedge clk) begin
        if (bus.o_wr) begin
            checks++;
            if (prev_wr) begin
                errors++;
                $display("FAIL wr_consecutive cycle %0d: o_wr high two cycles in a row, required single-cycle", cycle);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_strobe cycle %0d: got strobe data %02h, required no strobe", cycle, bus.o_data);
            end else begin
                e = sb.pop_front();
                if (bus.o_data !== e.data) begin
                    errors++;
                    $display("FAIL strobe_data cycle %0d: got %02h, required %02h", cycle, bus.o_data, e.data);
                end
                checks++;
                if (cycle != e.when) begin
                    errors++;
                    $display("FAIL strobe_time: got cycle %0d, required cycle %0d", cycle, e.when);
                end
                model_data = e.data;
            end
        end else if (sb.size() > 0 && cycle > sb[0].when) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe: no strobe by cycle %0d, required data %02h at cycle %0d", cycle, sb[0].data, sb[0].when);
            e = sb.pop_front();
            model_data = e.data;
        end
        checks++;
        if (bus.o_data !== model_data) begin
            errors++;
            $display("FAIL data_stable cycle %0d: got o_data %02h, required %02h", cycle, bus.o_data, model_data);
        end
        prev_wr = bus.o_wr;
    end

    // Drive the line with level v for n cycles (called just after a posedge)
    task automatic hold(input logic v, input int n);
        bus.i_uart_rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full 8N1 frame; a good stop bit means one strobe is expected
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [7:0] d;
        d = b;
        if (stop_bit) sb.push_back('{d, cycle + LAT});
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(stop_bit, CPB);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] fr;
        int         sel;
        fr = 8'h12;
        bus.i_uart_rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.o_wr !== 1'b0 || bus.o_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got o_wr %b o_data %02h, required 0 00", bus.o_wr, bus.o_data);
        end
        rst_n = 1'b1;
        hold(1'b1, 20);

        // Single frame, ideal timing
        send_frame(8'h55, 1'b1);
        hold(1'b1, 50);

        // Back-to-back frames with no idle gap
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        hold(1'b1, 30);

        // Short low glitch, then a good frame
        hold(1'b0, 20);
        hold(1'b1, CPB);
        send_frame(8'h3C, 1'b1);

        // Framing error, 200 idle cycles, then a good frame
        send_frame(8'h81, 1'b0);
        hold(1'b1, 200);
        send_frame(8'h7E, 1'b1);

        // Break of 30 bit times, then a frame of all ones
        hold(1'b0, 30 * CPB);
        hold(1'b1, CPB);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 40);

        // Reset in the middle of the data bits of a frame
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(fr[i], CPB);
        hold(fr[4], HALF);
        rst_n = 1'b0;
        bus.i_uart_rx = 1'b1;
        model_data = 8'h00;
        #1;
        checks++;
        if (bus.o_wr !== 1'b0 || bus.o_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_midframe: got o_wr %b o_data %02h, required 0 00", bus.o_wr, bus.o_data);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b1, 2 * CPB);
        send_frame(8'h00, 1'b1);
        hold(1'b1, 10);

        // Randomized mix of frames, glitches and framing errors
        for (int n = 0; n < 25; n++) begin
            sel = $urandom_range(0, 9);
            rb  = 8'($urandom_range(0, 255));
            if (sel <= 5) begin
                send_frame(rb, 1'b1);
                hold(1'b1, $urandom_range(0, CPB));
            end else if (sel <= 7) begin
                hold(1'b0, $urandom_range(1, HALF - 10));
                hold(1'b1, CPB + $urandom_range(0, 50));
            end else if (sel == 8) begin
                send_frame(rb, 1'b0);
                hold(1'b1, $urandom_range(1, 200));
            end else begin
                send_frame(rb, 1'b1);
            end
        end
        hold(1'b1, 3 * CPB);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending strobes, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
